// File: rtl/div_issue_ctrl_if.sv
// Bundle of the request ports, divider hookup and writeback port of div_issue_ctrl.
// slave is the controller's view; master is the view of everything around it.
interface div_issue_ctrl_if #(
  parameter int unsigned TAG_W = 6
);
  // Issue port 0
  logic             req0_valid;
  logic             req0_ready;
  logic [4:0]       req0_op;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;
  // Issue port 1
  logic             req1_valid;
  logic             req1_ready;
  logic [4:0]       req1_op;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;
  // Pipeline control
  logic             flush;
  // Shared divider
  logic             div_start;
  logic [4:0]       div_op_sel;
  logic [31:0]      div_rs1;
  logic [31:0]      div_rs2;
  logic             div_busy;
  logic             div_done;
  logic [31:0]      div_result;
  // Writeback
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_src;
  logic [31:0]      stat_ops;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  flush, div_busy, div_done, div_result, out_ready,
    output req0_ready, req1_ready,
    output div_start, div_op_sel, div_rs1, div_rs2,
    output out_valid, out_data, out_tag, out_src, stat_ops
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output flush, div_busy, div_done, div_result, out_ready,
    input  req0_ready, req1_ready,
    input  div_start, div_op_sel, div_rs1, div_rs2,
    input  out_valid, out_data, out_tag, out_src, stat_ops
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Two-port round-robin issue controller in front of one shared iterative divider.
// Holds operands for the whole divider run, sequences start/done and returns
// tagged results through a single-entry valid/ready output register.
module div_issue_ctrl #(
  parameter int unsigned TAG_W = 6
) (
  input logic            clk,
  input logic            rst_n,
  div_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             kill_q, kill_d;
  logic [4:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_src_q, out_src_d;
  logic [31:0]      stat_q, stat_d;

  logic             accept_ok;
  logic             accept;
  logic             gnt;
  logic [4:0]       sel_op;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic             sel_op_ok;
  logic             unused_busy;

  // The divider's busy flag is informational only; sequencing relies on done.
  assign unused_busy = bus.div_busy;

  // Grant selection and acceptance qualification.
  always_comb begin
    // A new op may only start once the output register is free or freeing,
    // so a later div_done always finds room for its result.
    accept_ok = (state_q == StIdle) && !bus.flush && (!out_valid_q || bus.out_ready);
    if (bus.req0_valid && bus.req1_valid) begin
      gnt = rr_q;
    end else begin
      gnt = bus.req1_valid;
    end
    accept    = accept_ok && (bus.req0_valid || bus.req1_valid);
    sel_op    = gnt ? bus.req1_op  : bus.req0_op;
    sel_a     = gnt ? bus.req1_a   : bus.req0_a;
    sel_b     = gnt ? bus.req1_b   : bus.req0_b;
    sel_tag   = gnt ? bus.req1_tag : bus.req0_tag;
    sel_op_ok = (sel_op[4:2] == 3'b101);
  end

  assign bus.req0_ready = accept && !gnt;
  assign bus.req1_ready = accept && gnt;

  // Next-state logic for the FSM, hold registers and output register.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    kill_d      = kill_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    src_d       = src_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_src_d   = out_src_q;
    stat_d      = stat_q;

    if (bus.flush) begin
      // A flushed result is not a delivery even if the consumer took it.
      out_valid_d = 1'b0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      stat_d      = stat_q + 32'd1;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = sel_op;
          a_d   = sel_a;
          b_d   = sel_b;
          tag_d = sel_tag;
          src_d = gnt;
          rr_d  = ~gnt;
          if (sel_op_ok) begin
            state_d = StLaunch;
          end else begin
            // Unsupported op: answer with zero straight away, divider untouched.
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_tag_d   = sel_tag;
            out_src_d   = gnt;
          end
        end
      end
      StLaunch: begin
        state_d = StWait;
        if (bus.flush) kill_d = 1'b1;
      end
      StWait: begin
        if (bus.flush) kill_d = 1'b1;
        if (bus.div_done) begin
          state_d = StIdle;
          kill_d  = 1'b0;
          if (!kill_q && !bus.flush) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.div_result;
            out_tag_d   = tag_q;
            out_src_d   = src_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      kill_q      <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      src_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_src_q   <= 1'b0;
      stat_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      kill_q      <= kill_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      src_q       <= src_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_src_q   <= out_src_d;
      stat_q      <= stat_d;
    end
  end

  assign bus.div_start  = (state_q == StLaunch);
  assign bus.div_op_sel = op_q;
  assign bus.div_rs1    = a_q;
  assign bus.div_rs2    = b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_src    = out_src_q;
  assign bus.stat_ops   = stat_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider, request driver with grant
// prediction, and a scoreboard monitor on the writeback port.
module tb_div_issue_ctrl;
  localparam int unsigned TAG_W = 6;

  typedef struct {
    logic [4:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             src;
    int               first;
    bit               seen;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  req_t pq0[$];
  req_t pq1[$];
  exp_t scb[$];

  div_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  div_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic bit op_valid(input logic [4:0] op);
    return (op >= 5'd20) && (op <= 5'd23);
  endfunction

  function automatic bit is_signed_ovf(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    return (op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      5'd20: r = (b == 0) ? 32'hFFFF_FFFF : is_signed_ovf(op, a, b) ? 32'h8000_0000 : 32'(sa / sb);
      5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: r = (b == 0) ? a : is_signed_ovf(op, a, b) ? 32'h0 : 32'(sa % sb);
      5'd23: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input req_t r);
    if (!op_valid(r.op)) return 1;
    if (r.b == 0 || is_signed_ovf(r.op, r.a, r.b)) return 4;
    return 37;
  endfunction

  function automatic req_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [TAG_W-1:0] tag);
    req_t r;
    r.op = op; r.a = a; r.b = b; r.tag = tag;
    return r;
  endfunction

  function automatic logic [31:0] rand_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // ---------------- divider model ----------------
  int          dv_rem;
  bit          dv_was_busy;
  bit          dv_stable;
  logic [4:0]  dv_op;
  logic [31:0] dv_a;
  logic [31:0] dv_b;

  // Fixed-latency divider: done 35 cycles after start, 2 on the bypass cases.
  initial begin
    dv_rem         = 0;
    bus.div_done   = 1'b0;
    bus.div_busy   = 1'b0;
    bus.div_result = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dv_rem         = 0;
        bus.div_done   = 1'b0;
        bus.div_busy   = 1'b0;
        bus.div_result = '0;
      end else begin
        bus.div_done = 1'b0;
        dv_was_busy  = (dv_rem > 0);
        if (dv_rem > 0) begin
          if (bus.div_op_sel !== dv_op || bus.div_rs1 !== dv_a || bus.div_rs2 !== dv_b)
            dv_stable = 1'b0;
          dv_rem--;
          if (dv_rem == 0) begin
            bus.div_done   = 1'b1;
            bus.div_result = ref_div(dv_op, dv_a, dv_b);
            check("operands_stable", dv_stable, 1);
          end
        end
        if (bus.div_start) begin
          check("start_while_busy", dv_was_busy, 0);
          check("start_op_valid", op_valid(bus.div_op_sel), 1);
          dv_op     = bus.div_op_sel;
          dv_a      = bus.div_rs1;
          dv_b      = bus.div_rs2;
          dv_stable = 1'b1;
          dv_rem    = (dv_b == 0 || is_signed_ovf(dv_op, dv_a, dv_b)) ? 2 : 35;
        end
        bus.div_busy = (dv_rem > 0);
      end
    end
  end

  // ---------------- request driver ----------------
  bit   rr_m;
  int   acc_cnt;
  int   last_acc_cyc;
  bit   d_v0, d_v1, d_a0, d_a1, d_g;
  req_t d_r;
  exp_t d_e;

  // Samples handshakes at negedge, predicts the grant, pushes expected results.
  initial begin
    rr_m = 1'b0; acc_cnt = 0; last_acc_cyc = 0;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_tag = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rr_m = 1'b0;
        scb.delete();
      end else begin
        d_v0 = bus.req0_valid;
        d_v1 = bus.req1_valid;
        d_a0 = d_v0 && bus.req0_ready;
        d_a1 = d_v1 && bus.req1_ready;
        if (bus.flush) check("ready_masked_on_flush", {bus.req0_ready, bus.req1_ready}, 0);
        if (d_a0 || d_a1) begin
          d_g = (d_v0 && d_v1) ? rr_m : d_v1;
          check("single_grant", d_a0 && d_a1, 0);
          check("grant_port", d_a1, d_g);
          if (d_a1) d_r = pq1.pop_front();
          else      d_r = pq0.pop_front();
          d_e.data  = op_valid(d_r.op) ? ref_div(d_r.op, d_r.a, d_r.b) : 32'h0;
          d_e.tag   = d_r.tag;
          d_e.src   = d_a1;
          d_e.first = cyc + exp_lat(d_r);
          d_e.seen  = 1'b0;
          scb.push_back(d_e);
          rr_m         = ~d_g;
          acc_cnt++;
          last_acc_cyc = cyc;
        end
        if (bus.flush) scb.delete();
      end
      @(posedge clk);
      #1;
      if (pq0.size() > 0) begin
        bus.req0_valid = 1'b1; bus.req0_op = pq0[0].op; bus.req0_a = pq0[0].a;
        bus.req0_b = pq0[0].b; bus.req0_tag = pq0[0].tag;
      end else begin
        bus.req0_valid = 1'b0;
      end
      if (pq1.size() > 0) begin
        bus.req1_valid = 1'b1; bus.req1_op = pq1[0].op; bus.req1_a = pq1[0].a;
        bus.req1_b = pq1[0].b; bus.req1_tag = pq1[0].tag;
      end else begin
        bus.req1_valid = 1'b0;
      end
    end
  end

  // ---------------- output monitor ----------------
  int stat_m;
  int last_hs_cyc;

  // Compares the writeback port against the head of the scoreboard.
  initial begin
    stat_m = 0;
    last_hs_cyc = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stat_m = 0;
      end else if (!bus.flush) begin
        if (scb.size() > 0 && cyc == scb[0].first) check("out_on_time", bus.out_valid, 1);
        if (bus.out_valid) begin
          if (scb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got out_valid tag %0h data %0h, expected no result (cycle %0d)",
                     bus.out_tag, bus.out_data, cyc);
          end else begin
            if (!scb[0].seen) begin
              check("out_latency", cyc, scb[0].first);
              scb[0].seen = 1'b1;
            end
            check("out_data", bus.out_data, scb[0].data);
            check("out_tag", bus.out_tag, scb[0].tag);
            check("out_src", bus.out_src, scb[0].src);
            if (bus.out_ready) begin
              check("stat_ops", bus.stat_ops, stat_m);
              stat_m++;
              void'(scb.pop_front());
              last_hs_cyc = cyc;
            end
          end
        end
      end
    end
  end

  // ---------------- sequence ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int prev, input string name, output int c);
    int k;
    k = 0;
    while (acc_cnt == prev && k < 500) begin
      tick(1);
      k++;
    end
    check(name, acc_cnt != prev, 1);
    c = last_acc_cyc;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((pq0.size() > 0 || pq1.size() > 0 || scb.size() > 0 || bus.div_busy || bus.out_valid)
           && k < 4000) begin
      tick(1);
      k++;
    end
    check(name, k < 4000, 1);
    tick(2);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_out_valid"}, bus.out_valid, 0);
    check({pfx, "_out_data"}, bus.out_data, 0);
    check({pfx, "_out_tag"}, bus.out_tag, 0);
    check({pfx, "_div_start"}, bus.div_start, 0);
    check({pfx, "_div_rs1"}, bus.div_rs1, 0);
    check({pfx, "_div_op_sel"}, bus.div_op_sel, 0);
    check({pfx, "_stat_ops"}, bus.stat_ops, 0);
    check({pfx, "_ready"}, {bus.req0_ready, bus.req1_ready}, 0);
  endtask

  int t0;
  int c1;
  int acc_before;
  int k;
  int tagc;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Signed divide -7 / 2 on port 0.
    pq0.push_back(mk(5'd20, 32'hFFFF_FFF9, 32'd2, 6'd5));
    wait_acc(acc_cnt, "accept_div", t0);
    wait_idle("drain_div");
    check("stat_ops_first", bus.stat_ops, 1);

    // Both ports busy: alternate grants.
    for (int i = 0; i < 4; i++) begin
      pq0.push_back(mk(5'd21, 32'd100, 32'd7, 6'(i)));
      pq1.push_back(mk(5'd23, 32'd100, 32'd7, 6'(8 + i)));
    end
    wait_idle("drain_rr");

    // Divider bypass cases.
    pq0.push_back(mk(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10));
    pq0.push_back(mk(5'd21, 32'd5, 32'd0, 6'd11));
    wait_idle("drain_bypass");

    // Back-pressure with port 1 pending.
    bus.out_ready = 1'b0;
    pq0.push_back(mk(5'd21, 32'd1000, 32'd3, 6'd12));
    pq1.push_back(mk(5'd20, 32'hFFFF_FC18, 32'd7, 6'd13));
    k = 0;
    while (!bus.out_valid && k < 200) begin
      tick(1);
      k++;
    end
    check("stall_first_out", bus.out_valid, 1);
    acc_before = acc_cnt;
    tick(50);
    check("no_accept_stalled", acc_cnt, acc_before);
    bus.out_ready = 1'b1;
    wait_acc(acc_before, "accept_after_stall", c1);
    check("accept_with_handshake", c1, last_hs_cyc);
    wait_idle("drain_stall");

    // Flush during WAIT: result dropped, next accept once the divider finishes.
    pq0.push_back(mk(5'd20, 32'd1234567, 32'd89, 6'd20));
    wait_acc(acc_cnt, "accept_flush_op", t0);
    while (cyc < t0 + 10) tick(1);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    acc_before = acc_cnt;
    pq0.push_back(mk(5'd20, 32'hFFFF_FF9C, 32'd7, 6'd21));
    wait_acc(acc_before, "accept_post_flush", c1);
    check("accept_after_kill", c1, t0 + 37);
    wait_idle("drain_flush");

    // Unsupported op code.
    pq0.push_back(mk(5'd0, 32'd7, 32'd3, 6'd3));
    wait_idle("drain_invalid");

    // Reset in the middle of a divide.
    pq0.push_back(mk(5'd20, 32'd999, 32'd4, 6'd30));
    wait_acc(acc_cnt, "accept_pre_reset", t0);
    while (cyc < t0 + 15) tick(1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("midreset");
    tick(1);
    rst_n = 1'b1;
    tick(60);
    check("stat_after_reset", bus.stat_ops, 0);

    // Random traffic with back-pressure and sporadic flushes.
    tagc = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0 && pq0.size() < 2) begin
        pq0.push_back(mk(($urandom_range(0, 9) < 8) ? 5'(20 + $urandom_range(0, 3))
                                                    : 5'($urandom_range(0, 19)),
                         rand_opnd(), rand_opnd(), 6'(tagc)));
        tagc++;
      end
      if ($urandom_range(0, 19) == 0 && pq1.size() < 2) begin
        pq1.push_back(mk(($urandom_range(0, 9) < 8) ? 5'(20 + $urandom_range(0, 3))
                                                    : 5'($urandom_range(24, 31)),
                         rand_opnd(), rand_opnd(), 6'(tagc)));
        tagc++;
      end
      tick(1);
    end
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Last-resort bound on total run time.
  initial begin
    #900000;
    failures++;
    $display("FAIL global_timeout: got still running expected finished (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
